// File: rtl/regfile_writeback_arbiter.sv
// Register-file write-port owner: zero-latency primary writeback plus an in-order
// FIFO of late multicycle results drained on idle cycles, with hazard and starvation flags.
module regfile_writeback_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       PriWrite,
    input  logic [4:0]                 PriReg,
    input  logic [31:0]                PriData,
    input  logic                       ReqValid,
    input  logic [4:0]                 ReqReg,
    input  logic [31:0]                ReqData,
    output logic                       ReqReady,
    output logic                       RegWrite,
    output logic [4:0]                 WriteReg,
    output logic [31:0]                WriteData,
    input  logic [4:0]                 ChkReg1,
    input  logic [4:0]                 ChkReg2,
    output logic                       Pending1,
    output logic                       Pending2,
    output logic                       Stall,
    output logic [$clog2(DEPTH):0]     Count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    logic [4:0]       memReg  [DEPTH];
    logic [31:0]      memData [DEPTH];
    logic [PTR_W-1:0] rdPtr, wrPtr;
    logic [CNT_W-1:0] occupancy;
    logic [STV_W-1:0] starveCnt, starveNext;
    logic             stallQ;
    logic             priActive, notEmpty, push, pop;

    function automatic logic [STV_W-1:0] satInc(input logic [STV_W-1:0] v);
        return (v == STV_W'(STARVE_MAX)) ? v : v + STV_W'(1);
    endfunction

    assign priActive = PriWrite && (PriReg != 5'd0);
    assign notEmpty  = (occupancy != '0);
    assign ReqReady  = (occupancy != CNT_W'(DEPTH));
    // Writes to r0 complete the handshake but are never stored.
    assign push      = ReqValid && ReqReady && (ReqReg != 5'd0);
    assign pop       = !priActive && notEmpty;
    assign Count     = occupancy;
    assign Stall     = stallQ;

    // Write port is forced idle while reset is held, independent of PriWrite.
    always_comb begin
        RegWrite  = 1'b0;
        WriteReg  = 5'd0;
        WriteData = 32'd0;
        if (reset) begin
            if (priActive) begin
                RegWrite  = 1'b1;
                WriteReg  = PriReg;
                WriteData = PriData;
            end else if (notEmpty) begin
                RegWrite  = 1'b1;
                WriteReg  = memReg[rdPtr];
                WriteData = memData[rdPtr];
            end
        end
    end

    always_comb begin
        logic [PTR_W-1:0] idx;
        Pending1 = 1'b0;
        Pending2 = 1'b0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rdPtr + PTR_W'(i);
            if (CNT_W'(i) < occupancy) begin
                if ((ChkReg1 != 5'd0) && (memReg[idx] == ChkReg1)) Pending1 = 1'b1;
                if ((ChkReg2 != 5'd0) && (memReg[idx] == ChkReg2)) Pending2 = 1'b1;
            end
        end
    end

    always_comb begin
        if (!notEmpty || pop) starveNext = '0;
        else                  starveNext = satInc(starveCnt);
    end

    // FIFO storage carries no reset; validity comes from occupancy alone.
    always_ff @(posedge clk) begin
        if (push) begin
            memReg[wrPtr]  <= ReqReg;
            memData[wrPtr] <= ReqData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            occupancy <= '0;
            starveCnt <= '0;
            stallQ    <= 1'b0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            case ({push, pop})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
            starveCnt <= starveNext;
            stallQ    <= (starveNext == STV_W'(STARVE_MAX));
        end
    end
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Scoreboard bench for regfile_writeback_arbiter: expected writes are queued at issue
// time and a negedge monitor checks every register-file write against them.
module tb_regfile_writeback_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        PriWrite;
    logic [4:0]  PriReg;
    logic [31:0] PriData;
    logic        ReqValid;
    logic [4:0]  ReqReg;
    logic [31:0] ReqData;
    logic        ReqReady;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  ChkReg1, ChkReg2;
    logic        Pending1, Pending2;
    logic        Stall;
    logic [2:0]  Count;

    int total = 0;
    int bad   = 0;
    logic [36:0] priQ[$];
    logic [36:0] fifoQ[$];

    regfile_writeback_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .PriWrite(PriWrite), .PriReg(PriReg), .PriData(PriData),
        .ReqValid(ReqValid), .ReqReg(ReqReg), .ReqData(ReqData), .ReqReady(ReqReady),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .ChkReg1(ChkReg1), .ChkReg2(ChkReg2), .Pending1(Pending1), .Pending2(Pending2),
        .Stall(Stall), .Count(Count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pw, input logic [4:0] pr, input logic [31:0] pd,
                         input logic rv, input logic [4:0] rr, input logic [31:0] rd,
                         input logic acc);
        PriWrite = pw; PriReg = pr; PriData = pd;
        ReqValid = rv; ReqReg = rr; ReqData = rd;
        if (pw && pr != 5'd0) priQ.push_back({pr, pd});
        if (rv && acc && rr != 5'd0) fifoQ.push_back({rr, rd});
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write on the port must match the head of the matching queue.
    always @(negedge clk) begin
        logic [36:0] exp;
        if (RegWrite === 1'b1) begin
            if (PriWrite && PriReg != 5'd0) begin
                if (priQ.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_pri_write: got=%0h want=none", {WriteReg, WriteData});
                end else begin
                    exp = priQ.pop_front();
                    chk("pri_write", {27'd0, WriteReg, WriteData}, {27'd0, exp});
                end
            end else begin
                if (fifoQ.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_fifo_write: got=%0h want=none", {WriteReg, WriteData});
                end else begin
                    exp = fifoQ.pop_front();
                    chk("fifo_write", {27'd0, WriteReg, WriteData}, {27'd0, exp});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, with a primary write presented that must stay gated
        reset = 1'b0; ChkReg1 = 5'd0; ChkReg2 = 5'd0;
        PriWrite = 1'b1; PriReg = 5'd5; PriData = 32'h1234;
        ReqValid = 1'b0; ReqReg = 5'd0; ReqData = 32'd0;
        #3;
        chk("rst_count", Count, 0);
        chk("rst_ready", ReqReady, 1);
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_stall", Stall, 0);
        chk("rst_pend", {Pending1, Pending2}, 0);
        idle();
        tick();
        reset = 1'b1;

        // Primary pass-through with empty FIFO
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("pri_regwrite", RegWrite, 1);
        chk("pri_wreg", WriteReg, 5);
        chk("pri_wdata", WriteData, 32'hDEADBEEF);
        tick();
        chk("pri_count", Count, 0);

        // In-order drain with pending tracking
        ChkReg1 = 5'd3; ChkReg2 = 5'd7;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h11, 1'b1);
        @(negedge clk);
        chk("bypass_none", RegWrite, 0);
        chk("pend_c0", {Pending1, Pending2}, 2'b00);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h22, 1'b1);
        @(negedge clk);
        chk("drain1_reg", WriteReg, 3);
        chk("pend_c1", {Pending1, Pending2}, 2'b10);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33, 1'b1);
        @(negedge clk);
        chk("drain2_reg", WriteReg, 7);
        chk("pend_c2", {Pending1, Pending2}, 2'b01);
        tick();
        idle();
        @(negedge clk);
        chk("drain3_data", WriteData, 32'h33);
        chk("pend_c3", {Pending1, Pending2}, 2'b10);
        tick();
        @(negedge clk);
        chk("pend_c4", {Pending1, Pending2}, 2'b00);
        chk("idle_regwrite", RegWrite, 0);
        chk("idle_wdata", WriteData, 0);
        chk("drained_count", Count, 0);
        tick();

        // Fill under a held primary write, starvation, then drain
        ChkReg1 = 5'd6; ChkReg2 = 5'd0;
        for (int i = 0; i < 4; i++) begin
            logic [4:0] r;
            r = (i == 0) ? 5'd1 : (i == 1) ? 5'd2 : (i == 2) ? 5'd4 : 5'd6;
            drive(1'b1, 5'd20, 32'hA000 + i, 1'b1, r, 32'h100 + i, 1'b1);
            tick();
        end
        chk("full_count", Count, 4);
        chk("full_ready", ReqReady, 0);
        chk("full_pend", Pending1, 1);
        drive(1'b1, 5'd20, 32'hA004, 1'b1, 5'd8, 32'h108, 1'b0);
        tick();
        chk("full_reject_count", Count, 4);
        chk("stall_at4", Stall, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd20, 32'hA010 + i, 1'b0, 5'd0, 32'd0, 1'b0);
            tick();
        end
        chk("stall_at7", Stall, 0);
        drive(1'b1, 5'd20, 32'hA020, 1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        chk("stall_at8", Stall, 1);
        drive(1'b1, 5'd20, 32'hA021, 1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("stall_pri_wins", WriteReg, 20);
        tick();
        chk("stall_held", Stall, 1);
        idle();
        tick();
        chk("stall_cleared", Stall, 0);
        tick(); tick(); tick();
        chk("drain4_count", Count, 0);
        chk("drain4_stall", Stall, 0);
        ChkReg1 = 5'd0;

        // r0 request and r0 primary
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF, 1'b1);
        @(negedge clk);
        chk("r0req_ready", ReqReady, 1);
        chk("r0req_nowrite", RegWrite, 0);
        tick();
        chk("r0req_count", Count, 0);
        drive(1'b1, 5'd9, 32'h909, 1'b1, 5'd12, 32'h55, 1'b1);
        tick();
        chk("r0pri_pre_count", Count, 1);
        drive(1'b1, 5'd0, 32'h777, 1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("r0pri_regwrite", RegWrite, 1);
        chk("r0pri_wreg", WriteReg, 12);
        chk("r0pri_wdata", WriteData, 32'h55);
        tick();
        chk("r0pri_count", Count, 0);

        // Reset in the middle of a drain
        drive(1'b1, 5'd9, 32'h9A, 1'b1, 5'd10, 32'hA0, 1'b1);
        tick();
        drive(1'b1, 5'd9, 32'h9B, 1'b1, 5'd11, 32'hB0, 1'b1);
        tick();
        chk("mid_count", Count, 2);
        idle();
        tick();
        chk("mid_count1", Count, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_regwrite", RegWrite, 0);
        chk("mid_rst_count", Count, 0);
        chk("mid_rst_ready", ReqReady, 1);
        fifoQ.delete();
        tick();
        #2;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        @(negedge clk);
        chk("post_rst_regwrite", RegWrite, 0);
        chk("post_rst_count", Count, 0);

        chk("priQ_empty", priQ.size(), 0);
        chk("fifoQ_empty", fifoQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_writeback_arbiter.md
Name: regfile_writeback_arbiter

Overview:
- Sits on the write side of the register file and owns its single write port (RegWrite/WriteReg/WriteData).
- Merges two writer classes:
  - the single-cycle datapath writeback (primary, unbuffered, highest priority);
  - late results from multicycle producers (load/mul/div), queued in a small FIFO and drained on idle write-port cycles.
- Also provides pending-write hazard flags for the read side and a starvation stall request.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- STARVE_MAX, 8, consecutive blocked cycles before Stall asserts; at least 1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (asserted when 0)
- PriWrite  in  1  primary datapath write enable
- PriReg  in  5  primary destination register
- PriData  in  32  primary write data
- ReqValid  in  1  queued-write request valid
- ReqReg  in  5  queued-write destination register
- ReqData  in  32  queued-write data
- ReqReady  out  1  FIFO can accept a request this cycle
- RegWrite  out  1  register-file write enable
- WriteReg  out  5  register-file write address
- WriteData  out  32  register-file write data
- ChkReg1  in  5  read-side register to check (port 1)
- ChkReg2  in  5  read-side register to check (port 2)
- Pending1  out  1  a queued write to ChkReg1 is outstanding
- Pending2  out  1  a queued write to ChkReg2 is outstanding
- Stall  out  1  request that the pipeline suppress PriWrite
- Count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- **Reset** (reset=0, async): FIFO empty, Count=0, read/write pointers 0, starve counter 0, Stall=0. RegWrite=0 while reset is low. Entry contents are don't-care.
- **ReqReady**: `ReqReady = (Count != DEPTH)`, combinational. It is not raised by a same-cycle pop.
- **Enqueue**: on a clk edge when ReqValid && ReqReady.
  - ReqReg==0: the handshake completes but nothing is stored; Count is unchanged.
  - ReqReg!=0: the entry is stored at the tail.
- **Primary path** (combinational pass-through, zero latency): when PriWrite && PriReg!=0, then RegWrite=1, WriteReg=PriReg, WriteData=PriData. The FIFO does not pop that cycle.
- **Drain**: when the primary path is inactive (PriWrite=0 or PriReg==0) and Count>0:
  - RegWrite=1 with WriteReg/WriteData taken from the head;
  - the head pops at the clk edge.
- **Idle**: no primary write and FIFO empty gives RegWrite=0, WriteReg=0, WriteData=0.
- **Bypass**: a request enqueued in a cycle is not drained in that same cycle (minimum queued latency is 1 cycle).
- **Simultaneous push and pop**: Count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- **Ordering**: the FIFO drains strictly in order. The arbiter does no reordering or entry killing. Program-order correctness relies on the control unit using the Pending flags.
- **Pending flags**:
  - `PendingN = 1` iff ChkRegN != 0 and any valid FIFO entry has reg == ChkRegN.
  - Combinational from current FIFO contents; requests being enqueued this cycle are excluded.
  - An entry popping this cycle still counts.
- **Starvation**:
  - The counter increments each cycle a primary write blocks a non-empty FIFO, saturating at STARVE_MAX.
  - It clears to 0 on any pop or when the FIFO is empty.
  - Stall is registered: 1 while counter == STARVE_MAX, otherwise 0.
  - While Stall=1 and PriWrite is still asserted, the primary write still wins. Stall is advisory.
- **Reset mid-operation**: queued writes are discarded and outputs return to their reset values immediately.

Test Plan:
1. Reset → Count=0, ReqReady=1, RegWrite=0, Stall=0, Pending1/2=0.
2. PriWrite=1, PriReg=5, PriData=32'hDEADBEEF with FIFO empty → same-cycle RegWrite=1, WriteReg=5, WriteData=32'hDEADBEEF; Count stays 0.
3. Enqueue (3,32'h11), (7,32'h22), (3,32'h33) with PriWrite=0 → writes appear in order on the 3 cycles following each enqueue. Pending1=1 for ChkReg1=3 until the last reg-3 entry pops, then 0.
4. PriWrite=1 held, enqueue DEPTH=4 entries → ReqReady=0 at Count=4, an extra ReqValid is not accepted, and Stall=1 after 8 blocked cycles. Drop PriWrite → 4 drain cycles, then Stall=0, Count=0.
5. ReqValid with ReqReg=0 and ReqData=32'hFFFF → accepted, Count unchanged, no write issued. PriWrite with PriReg=0 and FIFO non-empty → FIFO head drains that cycle.
6. Count=2, assert reset low mid-drain → RegWrite=0 immediately and Count=0. After release, no stale writes appear.
